e203_mvu_apb_bridge: RTL and testbench
======================================

Name: e203_mvu_apb_bridge

Overview:
- Parametrised ICB-to-APB4 bridge that connects the E203 subsystem's MVU peripheral ICB port to N MVU register slaves.
- Successor to the current single-slave MVU APB link, which supports only one slave and has no wait-state or error signalling. This block adds:
  - per-slave address decode and PSEL,
  - PREADY wait states,
  - PSLVERR error propagation,
  - PSTRB byte strobes,
  - a bounded-wait timeout.
- Sits inside e203_soc_top, between e203_subsys_top and the MVU array.

Parameters:
- N_MVU, 8, number of APB slaves (1..16).
- AW, 32, ICB/APB address width.
- DW, 32, data width (multiple of 8).
- SLV_WIN_BITS, 12, log2 of per-slave address window in bytes.
- TIMEOUT_CYC, 255, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  DW/8  byte mask
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_err  out  1  response error
- icb_rsp_rdata  out  DW  read data
- apb_paddr  out  AW  latched address
- apb_pwrite  out  1  write strobe
- apb_psel  out  N_MVU  one-hot slave select
- apb_penable  out  1  access phase
- apb_pwdata  out  DW  write data
- apb_pstrb  out  DW/8  byte strobes
- apb_prdata  in  N_MVU*DW  concatenated slave read data; slave i occupies [i*DW +: DW]
- apb_pready  in  N_MVU  per-slave ready
- apb_pslverr  in  N_MVU  per-slave error

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is asynchronous, active-low.
  - On reset: FSM=IDLE; icb_cmd_ready=1; all other outputs and registers reset to 0.
  - Reset asserted mid-transfer drops apb_psel/apb_penable immediately and discards the transfer; no response is issued.
- Decode:
  - IDXW = clog2(N_MVU), minimum 1.
  - idx = icb_cmd_addr[SLV_WIN_BITS +: IDXW].
  - idx >= N_MVU is a decode error.
  - Address bits above the index field are ignored; upstream ICB routing already selected this port.
- FSM (one outstanding transaction; icb_cmd_ready=1 only in IDLE):
  - IDLE: on icb_cmd_valid, latch addr, read, wdata, wmask and idx.
    - Decode error: go to RESP with err=1, rdata=0. No APB activity.
    - Otherwise: go to SETUP.
  - SETUP: apb_psel[idx]=1, penable=0; clear the timeout counter; go to ACCESS.
  - ACCESS: psel[idx]=1, penable=1.
    - If apb_pready[idx]: capture rdata = read ? prdata slice : 0; err = pslverr[idx]; drop psel/penable next cycle; go to RESP.
    - Else, if TIMEOUT_CYC != 0: increment the counter. When the counter reaches TIMEOUT_CYC, abort: err=1, rdata=0, go to RESP.
  - RESP: icb_rsp_valid=1; rsp_err and rsp_rdata held stable. On icb_rsp_ready go to IDLE.
- APB outputs:
  - apb_pwrite = ~read.
  - apb_pstrb = read ? 0 : wmask.
  - paddr, pwrite, pwdata and pstrb are stable from SETUP through the last ACCESS cycle.
- Latency and throughput:
  - Command accepted at cycle 0, SETUP at cycle 1, ACCESS at cycle 2.
  - With zero wait states, rsp_valid asserts at cycle 3.
  - Each wait state adds 1 cycle.
  - Decode error: rsp_valid at cycle 1.
  - Back-to-back throughput is at best one transfer per 4 cycles.
- Boundary conditions:
  - PREADY arriving in the same cycle the counter reaches TIMEOUT_CYC: PREADY wins (normal completion).
  - PREADY/PSLVERR from non-selected slaves are ignored.
  - Backpressure: rsp_ready low holds RESP indefinitely, and icb_cmd_ready stays 0 throughout.
  - The timeout counter is clog2(TIMEOUT_CYC+1) bits wide and saturates; it never wraps.

Decomposition:
- Shared defines/package (alongside the e203 defines):
  - FSM state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3),
  - the timeout-abort read value (0),
  - the index-width helper.
- One sub-module, e203_mvu_apb_rdmux: combinational selection of prdata/pready/pslverr by idx.
- The FSM, latches and timeout counter stay in the top.

Test Plan:
- Write addr=0x0000_1010, wdata=0xA5A5_1234, wmask=4'b0011; slave 1 pready=1 immediately → psel=8'b0000_0010, pstrb=4'b0011, pwrite=1; rsp_valid at cycle 3 with err=0, rdata=0.
- Read addr=0x0000_3000; slave 3 holds pready low for 5 cycles, prdata=0xCAFE_F00D → penable high for 6 cycles; rsp rdata=0xCAFE_F00D, err=0, rsp_valid at cycle 8.
- Read with N_MVU=6, addr=0x0000_7000 (idx 7) → no psel activity; rsp_valid at cycle 1 with err=1, rdata=0.
- Slave 2 returns pslverr=1 with pready → rsp err=1; next command accepted only after rsp handshake.
- TIMEOUT_CYC=4, slave never ready → abort after 4 ACCESS cycles; psel drops; err=1, rdata=0. Repeat with pready in exactly the 4th cycle → err=0.
- rst_n asserted during ACCESS → psel/penable=0 in the same cycle with no rsp_valid; after release, a new write completes normally.

Source files
------------

// File: rtl/e203_mvu_apb_bridge_pkg.sv
// Shared definitions for the MVU ICB-to-APB4 bridge: FSM state encoding,
// the read value returned on an aborted or undecodable access, and width helpers.
package e203_mvu_apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Read data reported for timeout aborts and decode errors
    localparam int unsigned ABORT_RDATA = 0;

    // Width of the slave index field; at least one bit even for a single slave
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of the saturating wait-state counter; one bit when the timeout is disabled
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/e203_mvu_apb_rdmux.sv
// Combinational per-slave return-path selector.
// Ports:
//   idx           - selected slave index
//   prdata        - concatenated slave read data, slave i at [i*DW +: DW]
//   pready        - per-slave ready
//   pslverr       - per-slave error
//   sel_rdata_c   - read data of the selected slave
//   sel_ready_c   - ready of the selected slave
//   sel_slverr_c  - error of the selected slave
module e203_mvu_apb_rdmux #(
    parameter int unsigned N_MVU = 8,
    parameter int unsigned DW    = 32,
    parameter int unsigned IDXW  = 3
) (
    input  logic [IDXW-1:0]     idx,
    input  logic [N_MVU*DW-1:0] prdata,
    input  logic [N_MVU-1:0]    pready,
    input  logic [N_MVU-1:0]    pslverr,
    output logic [DW-1:0]       sel_rdata_c,
    output logic                sel_ready_c,
    output logic                sel_slverr_c
);

    // Compare-and-select so an out-of-range idx simply yields zeros
    always_comb begin
        sel_rdata_c  = '0;
        sel_ready_c  = 1'b0;
        sel_slverr_c = 1'b0;
        for (int unsigned i = 0; i < N_MVU; i++) begin
            if (idx == IDXW'(i)) begin
                sel_rdata_c  = prdata[i*DW +: DW];
                sel_ready_c  = pready[i];
                sel_slverr_c = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/e203_mvu_apb_bridge.sv
// ICB-to-APB4 bridge fanning the MVU peripheral port out to N_MVU register slaves.
// One outstanding transfer; per-slave decode/PSEL, wait states, PSLVERR
// propagation, byte strobes and an optional bounded-wait timeout.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   icb_cmd_*                        - ICB command channel (valid/ready/addr/read/wdata/wmask)
//   icb_rsp_*                        - ICB response channel (valid/ready/err/rdata)
//   apb_paddr/pwrite/pwdata/pstrb    - latched APB request fields
//   apb_psel/apb_penable             - one-hot slave select, access phase
//   apb_prdata/apb_pready/apb_pslverr- concatenated/per-slave slave returns
module e203_mvu_apb_bridge
    import e203_mvu_apb_bridge_pkg::*;
#(
    parameter int unsigned N_MVU        = 8,
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned SLV_WIN_BITS = 12,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                icb_cmd_valid,
    output logic                icb_cmd_ready,
    input  logic [AW-1:0]       icb_cmd_addr,
    input  logic                icb_cmd_read,
    input  logic [DW-1:0]       icb_cmd_wdata,
    input  logic [DW/8-1:0]     icb_cmd_wmask,
    output logic                icb_rsp_valid,
    input  logic                icb_rsp_ready,
    output logic                icb_rsp_err,
    output logic [DW-1:0]       icb_rsp_rdata,
    output logic [AW-1:0]       apb_paddr,
    output logic                apb_pwrite,
    output logic [N_MVU-1:0]    apb_psel,
    output logic                apb_penable,
    output logic [DW-1:0]       apb_pwdata,
    output logic [DW/8-1:0]     apb_pstrb,
    input  logic [N_MVU*DW-1:0] apb_prdata,
    input  logic [N_MVU-1:0]    apb_pready,
    input  logic [N_MVU-1:0]    apb_pslverr
);

    localparam int unsigned IDXW = idx_width(N_MVU);
    localparam int unsigned TCW  = cnt_width(TIMEOUT_CYC);
    localparam int unsigned SW   = DW / 8;

    state_e            state_q, state_nxt;
    logic [IDXW-1:0]   idx_q, idx_in, idx_nxt;
    logic              read_q;
    logic [TCW-1:0]    cnt_q, cnt_nxt, cnt_inc;
    logic              err_nxt;
    logic [DW-1:0]     rdata_nxt;
    logic              latch_c;
    logic [N_MVU-1:0]  psel_nxt;
    logic [DW-1:0]     sel_rdata;
    logic              sel_ready, sel_slverr;

    assign idx_in = icb_cmd_addr[SLV_WIN_BITS +: IDXW];

    e203_mvu_apb_rdmux #(
        .N_MVU (N_MVU),
        .DW    (DW),
        .IDXW  (IDXW)
    ) u_rdmux (
        .idx          (idx_q),
        .prdata       (apb_prdata),
        .pready       (apb_pready),
        .pslverr      (apb_pslverr),
        .sel_rdata_c  (sel_rdata),
        .sel_ready_c  (sel_ready),
        .sel_slverr_c (sel_slverr)
    );

    // Saturating increment so the counter can never wrap
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TCW'(1);

    // Next-state, response capture and timeout counter
    always_comb begin
        state_nxt = state_q;
        latch_c   = 1'b0;
        cnt_nxt   = cnt_q;
        err_nxt   = icb_rsp_err;
        rdata_nxt = icb_rsp_rdata;
        idx_nxt   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (icb_cmd_valid) begin
                    latch_c   = 1'b1;
                    idx_nxt   = idx_in;
                    err_nxt   = 1'b0;
                    rdata_nxt = '0;
                    if (32'(idx_in) >= N_MVU) begin
                        err_nxt   = 1'b1;
                        rdata_nxt = DW'(ABORT_RDATA);
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                cnt_nxt   = '0;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready in the cycle the count hits the limit still completes normally
                if (sel_ready) begin
                    rdata_nxt = read_q ? sel_rdata : '0;
                    err_nxt   = sel_slverr;
                    state_nxt = ST_RESP;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TCW'(TIMEOUT_CYC)) begin
                        err_nxt   = 1'b1;
                        rdata_nxt = DW'(ABORT_RDATA);
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (icb_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        psel_nxt = '0;
        if (state_nxt == ST_SETUP || state_nxt == ST_ACCESS) begin
            psel_nxt = N_MVU'(1) << idx_nxt;
        end
    end

    // State, registered outputs and command latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            read_q        <= 1'b0;
            icb_cmd_ready <= 1'b1;
            icb_rsp_valid <= 1'b0;
            icb_rsp_err   <= 1'b0;
            icb_rsp_rdata <= '0;
            apb_paddr     <= '0;
            apb_pwrite    <= 1'b0;
            apb_psel      <= '0;
            apb_penable   <= 1'b0;
            apb_pwdata    <= '0;
            apb_pstrb     <= '0;
        end else begin
            state_q       <= state_nxt;
            cnt_q         <= cnt_nxt;
            idx_q         <= idx_nxt;
            icb_cmd_ready <= (state_nxt == ST_IDLE);
            icb_rsp_valid <= (state_nxt == ST_RESP);
            icb_rsp_err   <= err_nxt;
            icb_rsp_rdata <= rdata_nxt;
            apb_psel      <= psel_nxt;
            apb_penable   <= (state_nxt == ST_ACCESS);
            if (latch_c) begin
                read_q     <= icb_cmd_read;
                apb_paddr  <= icb_cmd_addr;
                apb_pwrite <= ~icb_cmd_read;
                apb_pwdata <= icb_cmd_wdata;
                apb_pstrb  <= icb_cmd_read ? SW'(0) : icb_cmd_wmask;
            end
        end
    end

endmodule

// File: tb/tb_e203_mvu_apb_bridge.sv
// Self-checking bench for e203_mvu_apb_bridge (6 slaves, 6-cycle timeout).
module tb_e203_mvu_apb_bridge;

    localparam int unsigned N   = 6;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned WIN = 12;
    localparam int unsigned TO  = 6;
    localparam int          NV  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [AW-1:0]     icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [SW-1:0]     icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic              icb_rsp_err;
    logic [DW-1:0]     icb_rsp_rdata;
    logic [AW-1:0]     apb_paddr;
    logic              apb_pwrite;
    logic [N-1:0]      apb_psel;
    logic              apb_penable;
    logic [DW-1:0]     apb_pwdata;
    logic [SW-1:0]     apb_pstrb;
    logic [N*DW-1:0]   apb_prdata;
    logic [N-1:0]      apb_pready;
    logic [N-1:0]      apb_pslverr;

    always #5 clk = ~clk;

    e203_mvu_apb_bridge #(
        .N_MVU        (N),
        .AW           (AW),
        .DW           (DW),
        .SLV_WIN_BITS (WIN),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata),
        .apb_paddr     (apb_paddr),
        .apb_pwrite    (apb_pwrite),
        .apb_psel      (apb_psel),
        .apb_penable   (apb_penable),
        .apb_pwdata    (apb_pwdata),
        .apb_pstrb     (apb_pstrb),
        .apb_prdata    (apb_prdata),
        .apb_pready    (apb_pready),
        .apb_pslverr   (apb_pslverr)
    );

    // waits: ACCESS cycles with PREADY low before ready; -1 = never ready
    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          hold;
        logic [5:0]  exp_psel;
        logic [3:0]  exp_pstrb;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        logic        psel_any;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   cyc;
        int   acc;
        logic done;
        logic psel_seen;
        logic bad_apb;
        logic bad_busy;
        logic bad_hold;
        logic sel_rdy;
        logic        h_err;
        logic [31:0] h_rdata;
        exp_t e;
        exp_t got;

        for (int i = 0; i < int'(N); i++) begin
            apb_prdata[i*DW +: DW] = (i == int'(v.addr[WIN +: 3])) ? v.prdata
                                                                     : (32'hDEAD_0000 | 32'(i));
        end
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = v.addr;
        icb_cmd_read  = v.rd;
        icb_cmd_wdata = v.wdata;
        icb_cmd_wmask = v.wmask;
        chk($sformatf("v%0d cmd_ready_idle", id), 64'(icb_cmd_ready), 64'd1);
        e.err      = v.exp_err;
        e.rdata    = v.exp_rdata;
        e.lat      = v.exp_lat;
        e.acc      = v.exp_acc;
        e.psel_any = (v.exp_psel != 6'd0);
        sb_q.push_back(e);

        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        cyc = 1; acc = 0; done = 1'b0;
        psel_seen = 1'b0; bad_apb = 1'b0; bad_busy = 1'b0; bad_hold = 1'b0;
        while (!done && cyc < 40) begin
            if (icb_rsp_valid) begin
                done = 1'b1;
            end else begin
                if (icb_cmd_ready) bad_busy = 1'b1;
                if (apb_psel != '0) begin
                    psel_seen = 1'b1;
                    if (apb_psel !== v.exp_psel || apb_paddr !== v.addr ||
                        apb_pwdata !== v.wdata || apb_pstrb !== v.exp_pstrb ||
                        apb_pwrite !== ~v.rd) bad_apb = 1'b1;
                end
                if (cyc == 1 && apb_penable) bad_apb = 1'b1;
                if (apb_penable) acc++;
                sel_rdy     = apb_penable && (v.waits >= 0) && (acc > v.waits);
                apb_pready  = ~apb_psel | (sel_rdy ? apb_psel : '0);
                apb_pslverr = ~apb_psel | (v.slverr ? apb_psel : '0);
                @(posedge clk); #1;
                cyc++;
            end
        end

        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d rsp_wait: no rsp_valid within %0d cycles", id, cyc);
            void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL v%0d scoreboard: rsp_valid with nothing expected", id);
        end else begin
            got = sb_q.pop_front();
            chk($sformatf("v%0d rsp_err", id),   64'(icb_rsp_err),   64'(got.err));
            chk($sformatf("v%0d rsp_rdata", id), 64'(icb_rsp_rdata), 64'(got.rdata));
            chk($sformatf("v%0d latency", id),   64'(cyc),           64'(got.lat));
            chk($sformatf("v%0d access_cycles", id), 64'(acc),       64'(got.acc));
            chk($sformatf("v%0d psel_activity", id), 64'(psel_seen), 64'(got.psel_any));
            chk($sformatf("v%0d apb_fields", id),    64'(bad_apb),   64'd0);
            chk($sformatf("v%0d cmd_ready_busy", id), 64'(bad_busy), 64'd0);
            chk($sformatf("v%0d psel_in_resp", id),
                64'({apb_psel, apb_penable}), 64'd0);
        end

        h_err = icb_rsp_err;
        h_rdata = icb_rsp_rdata;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (!icb_rsp_valid || icb_cmd_ready || icb_rsp_err !== h_err ||
                icb_rsp_rdata !== h_rdata) bad_hold = 1'b1;
        end
        if (v.hold > 0) chk($sformatf("v%0d backpressure_hold", id), 64'(bad_hold), 64'd0);

        icb_rsp_ready = 1'b1;
        @(posedge clk); #1;
        icb_rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_valid_drop", id), 64'(icb_rsp_valid), 64'd0);
        chk($sformatf("v%0d cmd_ready_back", id), 64'(icb_cmd_ready), 64'd1);
    endtask

    initial begin
        int   n;
        vec_t rv;

        vecs[0] = '{32'h0000_1010, 1'b0, 32'hA5A5_1234, 4'b0011,  0, 1'b0, 32'h0,         0, 6'b000010, 4'b0011, 1'b0, 32'h0,         3, 1};
        vecs[1] = '{32'h0000_3000, 1'b1, 32'h1111_0000, 4'b1111,  5, 1'b0, 32'hCAFE_F00D, 0, 6'b001000, 4'b0000, 1'b0, 32'hCAFE_F00D, 8, 6};
        vecs[2] = '{32'h0000_7000, 1'b1, 32'h0,         4'b1111,  0, 1'b0, 32'h0,         2, 6'b000000, 4'b0000, 1'b1, 32'h0,         1, 0};
        vecs[3] = '{32'h0000_2004, 1'b0, 32'h0BAD_CAFE, 4'b1100,  1, 1'b1, 32'h5555_5555, 3, 6'b000100, 4'b1100, 1'b1, 32'h0,         4, 2};
        vecs[4] = '{32'h0000_0008, 1'b1, 32'h0,         4'b0000, -1, 1'b0, 32'h1234_5678, 0, 6'b000001, 4'b0000, 1'b1, 32'h0,         8, 6};
        vecs[5] = '{32'h0000_5FFC, 1'b1, 32'h0,         4'b0000,  0, 1'b0, 32'h0BAD_BEEF, 0, 6'b100000, 4'b0000, 1'b0, 32'h0BAD_BEEF, 3, 1};
        vecs[6] = '{32'h0000_6000, 1'b0, 32'hFFFF_FFFF, 4'b1111,  0, 1'b0, 32'h0,         0, 6'b000000, 4'b0000, 1'b1, 32'h0,         1, 0};
        vecs[7] = '{32'hFFFF_4000, 1'b1, 32'h0,         4'b0000,  2, 1'b0, 32'h4444_4444, 0, 6'b010000, 4'b0000, 1'b0, 32'h4444_4444, 5, 3};
        vecs[8] = '{32'h0000_0FFC, 1'b0, 32'hDEAD_BEEF, 4'b1111,  0, 1'b0, 32'h0,         1, 6'b000001, 4'b1111, 1'b0, 32'h0,         3, 1};
        vecs[9] = '{32'h0000_1000, 1'b1, 32'h0,         4'b0000,  0, 1'b1, 32'h1111_2222, 0, 6'b000010, 4'b0000, 1'b1, 32'h1111_2222, 3, 1};

        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b0;
        apb_prdata    = '0;
        apb_pready    = '0;
        apb_pslverr   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset cmd_ready", 64'(icb_cmd_ready), 64'd1);
        chk("reset rsp", 64'({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}), 64'd0);
        chk("reset apb", 64'({apb_psel, apb_penable, apb_pwrite, apb_pstrb}), 64'd0);
        chk("reset paddr_pwdata", {apb_paddr, apb_pwdata}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset cmd_ready", 64'(icb_cmd_ready), 64'd1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset during ACCESS: select and enable drop immediately, no response follows
        rv = vecs[4];
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = rv.addr;
        icb_cmd_read  = 1'b1;
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        n = 0;
        while (!apb_penable && n < 10) begin
            apb_pready = ~apb_psel;
            @(posedge clk); #1;
            n++;
        end
        apb_pready = ~apb_psel;
        chk("rst_mid reached_access", 64'(apb_penable), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid psel_penable", 64'({apb_psel, apb_penable}), 64'd0);
        chk("rst_mid rsp_valid", 64'(icb_rsp_valid), 64'd0);
        chk("rst_mid cmd_ready", 64'(icb_cmd_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_after rsp_valid", 64'(icb_rsp_valid), 64'd0);
        run_vec(vecs[0], 100);
        chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
